// File: rtl/dshot_frame_decoder_if.sv
// DShot receiver bundle: serial line and enable in, decoded frame fields and status out.
interface dshot_frame_decoder_if;
   logic        enable;
   logic        dshot_in;
   logic [10:0] throttle;
   logic        telemetry;
   logic        frame_valid;
   logic        frame_error;
   logic        busy;

   modport master (
      output enable, dshot_in,
      input  throttle, telemetry, frame_valid, frame_error, busy
   );

   modport slave (
      input  enable, dshot_in,
      output throttle, telemetry, frame_valid, frame_error, busy
   );
endinterface

// File: rtl/dshot_frame_decoder.sv
// DShot frame receiver: measures pulse high time against the bit period,
// assembles 16 bits MSB first and latches throttle/telemetry on a good CRC.
module dshot_frame_decoder #(
   parameter int unsigned BAUD = 150000
) (
   input logic                  clk_in,
   input logic                  reset,
   dshot_frame_decoder_if.slave bus
);
   localparam int unsigned BIT_CYCLES = (BAUD == 600000) ? 27 :
                                        (BAUD == 300000) ? 53 : 107;
   localparam int unsigned TIMEOUT    = 2 * BIT_CYCLES;
   localparam int unsigned CW         = $clog2(TIMEOUT + 1);

   localparam logic [CW-1:0] HALF_C   = CW'(BIT_CYCLES >> 1);
   localparam logic [CW-1:0] GLITCH_C = CW'(BIT_CYCLES >> 3);
   // Fault limits sit one below the threshold: the fault fires on the cycle the count would reach it.
   localparam logic [CW-1:0] STUCK_LIM   = CW'(BIT_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LIM = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_ONE     = CW'(1);

   typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW, ST_CHECK} state_t;

   state_t        state;
   logic [1:0]    sync_q;
   logic          hist_q;
   logic [CW-1:0] cnt;
   logic [4:0]    bit_idx;
   logic [15:0]   shift;
   logic [10:0]   throttle_q;
   logic          telemetry_q;
   logic          valid_q;
   logic          error_q;
   logic          busy_q;

   logic       rise;
   logic       fall;
   logic [3:0] crc;
   logic       crc_ok;

   assign rise   = sync_q[1] & ~hist_q;
   assign fall   = ~sync_q[1] & hist_q;
   assign crc    = shift[7:4] ^ shift[11:8] ^ shift[15:12];
   assign crc_ok = (crc == shift[3:0]);

   always_ff @(posedge clk_in) begin
      if (reset) begin
         sync_q      <= '0;
         hist_q      <= 1'b0;
         state       <= ST_IDLE;
         cnt         <= '0;
         bit_idx     <= '0;
         shift       <= '0;
         throttle_q  <= '0;
         telemetry_q <= 1'b0;
         valid_q     <= 1'b0;
         error_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], bus.dshot_in};
         hist_q  <= sync_q[1];
         valid_q <= 1'b0;
         error_q <= 1'b0;
         if (!bus.enable) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            busy_q  <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (rise) begin
                     state   <= ST_HIGH;
                     cnt     <= CNT_ONE;
                     bit_idx <= '0;
                     busy_q  <= 1'b1;
                  end
               end
               ST_HIGH: begin
                  if (fall && (cnt < GLITCH_C)) begin
                     error_q <= 1'b1;
                     state   <= ST_IDLE;
                     cnt     <= '0;
                     shift   <= '0;
                     busy_q  <= 1'b0;
                  end else if (fall) begin
                     shift   <= {shift[14:0], (cnt >= HALF_C)};
                     bit_idx <= bit_idx + 5'd1;
                     cnt     <= CNT_ONE;
                     state   <= ST_LOW;
                  end else if (cnt >= STUCK_LIM) begin
                     error_q <= 1'b1;
                     state   <= ST_IDLE;
                     cnt     <= '0;
                     shift   <= '0;
                     busy_q  <= 1'b0;
                  end else begin
                     cnt <= cnt + CNT_ONE;
                  end
               end
               ST_LOW: begin
                  // Verdict is registered on entry to CHECK so the pulse coincides with that cycle.
                  if (bit_idx == 5'd16) begin
                     if (crc_ok) begin
                        throttle_q  <= shift[15:5];
                        telemetry_q <= shift[4];
                        valid_q     <= 1'b1;
                     end else begin
                        error_q <= 1'b1;
                     end
                     cnt   <= '0;
                     state <= ST_CHECK;
                  end else if (cnt >= TIMEOUT_LIM) begin
                     error_q <= 1'b1;
                     state   <= ST_IDLE;
                     cnt     <= '0;
                     shift   <= '0;
                     busy_q  <= 1'b0;
                  end else if (rise) begin
                     cnt   <= CNT_ONE;
                     state <= ST_HIGH;
                  end else begin
                     cnt <= cnt + CNT_ONE;
                  end
               end
               ST_CHECK: begin
                  state   <= ST_IDLE;
                  bit_idx <= '0;
                  shift   <= '0;
                  busy_q  <= 1'b0;
               end
               default: begin
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.throttle    = throttle_q;
   assign bus.telemetry   = telemetry_q;
   assign bus.frame_valid = valid_q;
   assign bus.frame_error = error_q;
   assign bus.busy        = busy_q;
endmodule
